// File: rtl/anemometre_dbg_pkg.sv
// Shared types and constants for the on-chip debug memory controller:
// FSM state encoding, default geometry and jdo payload field positions.
package anemometre_dbg_pkg;

    localparam int unsigned DEPTH_DEF = 256;
    localparam int unsigned AW_DEF    = 8;

    localparam int unsigned JDO_ADDR_HI  = 33;
    localparam int unsigned JDO_ADDR_LO  = 26;
    localparam int unsigned JDO_RDEN     = 25;
    localparam int unsigned JDO_WDATA_HI = 34;
    localparam int unsigned JDO_WDATA_LO = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JRD,
        ST_JWR,
        ST_CRD,
        ST_CWR
    } dbg_state_e;

endpackage

// File: rtl/anemometre_dbg_ram.sv
// Single-port DEPTH x 32 synchronous RAM, one-cycle registered read,
// per-byte write enables.
module anemometre_dbg_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Only the output register is reset so CPU read data starts at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/anemometre_dbg_ocimem.sv
// Nios II on-chip debug memory: JTAG ocimem strobes and an Avalon-MM CPU slave
// share one debug RAM, JTAG first. ANEMO_DBGMEM_WRPROT_EN blocks CPU writes outside debug mode.
//
// state | meaning
// IDLE  | arbitrate: queued JTAG access first, then CPU read/write
// JRD   | JTAG read, RAM address presented; MonDReg loads next cycle
// JWR   | JTAG write, all byte lanes, RAM written this cycle
// CRD   | CPU read, wait state then completion cycle
// CWR   | CPU write, completes this cycle
module anemometre_dbg_ocimem
    import anemometre_dbg_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic          debugack,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          mon_busy,
    output logic          mon_err,
    output logic          cpu_wr_err
);

    dbg_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pend_q, pend_d;
    logic          pend_wr_q, pend_wr_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          crd_ph_q, crd_ph_d;
    logic          rd_cap_q, rd_cap_d;
    logic          mon_err_q, mon_err_d;
    logic [31:0]   mon_q, mon_d;

    logic          enq_req, accept, deq, cpu_wr_blk, unused_ok;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata, ram_rdata;

`ifdef ANEMO_DBGMEM_WRPROT_EN
    assign cpu_wr_blk = ~debugack;
    assign unused_ok  = ^{jdo[37:35], jdo[2:0]};
`else
    assign cpu_wr_blk = 1'b0;
    assign unused_ok  = ^{jdo[37:35], jdo[2:0], debugack};
`endif

    assign enq_req = take_action_ocimem_b | (take_action_ocimem_a & jdo[JDO_RDEN])
                   | take_no_action_ocimem_a;
    assign deq     = (state_q == ST_IDLE) && pend_q;
    // The single slot may be refilled in the same cycle it is drained.
    assign accept  = enq_req && (!pend_q || deq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q)         state_d = pend_wr_q ? ST_JWR : ST_JRD;
                else if (accept)    state_d = ST_IDLE;
                else if (avs_read)  state_d = ST_CRD;
                else if (avs_write) state_d = ST_CWR;
            end
            ST_JRD, ST_JWR: begin
                if (pend_q || accept) state_d = ST_IDLE;
                else if (avs_read)    state_d = ST_CRD;
                else if (avs_write)   state_d = ST_CWR;
                else                  state_d = ST_IDLE;
            end
            ST_CRD:  if (crd_ph_q) state_d = ST_IDLE;
            ST_CWR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr   = avs_address;
        ram_we     = 1'b0;
        ram_be     = avs_byteenable;
        ram_wdata  = avs_writedata;
        case (state_q)
            ST_JRD: ram_addr = addr_q;
            ST_JWR: begin
                ram_addr  = addr_q;
                ram_we    = 1'b1;
                ram_be    = 4'hF;
                ram_wdata = wdata_q;
            end
            ST_CWR:  ram_we = ~cpu_wr_blk;
            default: ;
        endcase
        avs_waitrequest = !(((state_q == ST_CRD) && crd_ph_q) || (state_q == ST_CWR));
        mon_busy        = pend_q || (state_q == ST_JRD) || (state_q == ST_JWR);
        cpu_wr_err      = (state_q == ST_CWR) && cpu_wr_blk;
    end

    always_comb begin
        addr_d = addr_q;
        if (take_action_ocimem_a)
            addr_d = AW'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
        else if ((state_q == ST_JRD) || (state_q == ST_JWR))
            addr_d = addr_q + AW'(1);

        pend_d      = pend_q;
        pend_wr_d   = pend_wr_q;
        pend_data_d = pend_data_q;
        if (deq) pend_d = 1'b0;
        if (accept) begin
            pend_d      = 1'b1;
            pend_wr_d   = take_action_ocimem_b;
            pend_data_d = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
        end

        mon_err_d = mon_err_q;
        if (take_action_ocimem_a) mon_err_d = 1'b0;
        if (enq_req && !accept)   mon_err_d = 1'b1;

        wdata_d  = deq ? pend_data_q : wdata_q;
        crd_ph_d = (state_q == ST_CRD) && !crd_ph_q;
        rd_cap_d = (state_q == ST_JRD);
        mon_d    = rd_cap_q ? ram_rdata : mon_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_data_q <= '0;
            wdata_q     <= '0;
            crd_ph_q    <= 1'b0;
            rd_cap_q    <= 1'b0;
            mon_err_q   <= 1'b0;
            mon_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_data_q <= pend_data_d;
            wdata_q     <= wdata_d;
            crd_ph_q    <= crd_ph_d;
            rd_cap_q    <= rd_cap_d;
            mon_err_q   <= mon_err_d;
            mon_q       <= mon_d;
        end
    end

    assign MonDReg      = mon_q;
    assign mon_err      = mon_err_q;
    assign avs_readdata = ram_rdata;

    anemometre_dbg_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_anemometre_dbg_ocimem.sv
// Scoreboard bench for anemometre_dbg_ocimem; honours ANEMO_DBGMEM_WRPROT_EN
// for the CPU write-protection expectations.
module tb_anemometre_dbg_ocimem;

`ifdef ANEMO_DBGMEM_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_b, take_na, debugack;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata, MonDReg;
    logic        avs_waitrequest, mon_busy, mon_err, cpu_wr_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem [256];
    logic [7:0]  model_addr;
    logic [31:0] exp_jq [$];
    logic [31:0] exp_cq [$];

    always #5 clk = ~clk;

    anemometre_dbg_ocimem dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .debugack                (debugack),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .mon_busy                (mon_busy),
        .mon_err                 (mon_err),
        .cpu_wr_err              (cpu_wr_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_a(input logic [7:0] a, input logic rden);
        jdo = '0;
        jdo[33:26] = a;
        jdo[25] = rden;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        model_addr = a;
        if (rden) begin
            exp_jq.push_back(model_mem[model_addr]);
            model_addr++;
        end
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        model_mem[model_addr] = d;
        model_addr++;
    endtask

    task automatic jtag_na();
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
        exp_jq.push_back(model_mem[model_addr]);
        model_addr++;
    endtask

    task automatic pop_mon(input string tag);
        if (exp_jq.size() == 0) chk({tag, "_sb"}, 32'(exp_jq.size()), 32'd1);
        else                    chk(tag, MonDReg, exp_jq.pop_front());
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && mon_busy; i++) tick();
        chk("idle", {31'd0, mon_busy}, 32'd0);
        tick();
    endtask

    task automatic cpu_read(input logic [7:0] a, input int exp_n, input bit with_b,
                            input logic [31:0] bdata);
        int n;
        if (with_b) begin
            jdo = '0;
            jdo[34:3] = bdata;
            take_b = 1'b1;
            model_mem[model_addr] = bdata;
            model_addr++;
        end
        exp_cq.push_back(model_mem[a]);
        avs_address = a;
        avs_read = 1'b1;
        n = 0;
        do begin
            tick();
            take_b = 1'b0;
            n++;
        end while (avs_waitrequest && n < 20);
        chk("crd_lat", n, exp_n);
        chk("crd_data", avs_readdata, exp_cq.pop_front());
        tick();
        avs_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        bit blocked;
        blocked = WRPROT && !debugack;
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_write = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (avs_waitrequest && n < 20);
        chk("cwr_lat", n, 1);
        chk("cwr_err", {31'd0, cpu_wr_err}, {31'd0, blocked});
        tick();
        avs_write = 1'b0;
        chk("cwr_err_pulse", {31'd0, cpu_wr_err}, 32'd0);
        if (!blocked)
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mon"},   MonDReg, 32'd0);
        chk({tag, "_wait"},  {31'd0, avs_waitrequest}, 32'd1);
        chk({tag, "_rdata"}, avs_readdata, 32'd0);
        chk({tag, "_busy"},  {31'd0, mon_busy}, 32'd0);
        chk({tag, "_err"},   {31'd0, mon_err}, 32'd0);
        chk({tag, "_wrerr"}, {31'd0, cpu_wr_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
        debugack = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = 4'hF;
        model_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_reset("rst");
        tick();

        // JTAG writes; busy covers pending + JWR, then clears
        jtag_a(8'h10, 1'b0);
        jtag_b(32'hDEADBEEF);
        chk("wr_busy0", {31'd0, mon_busy}, 32'd1);
        tick();
        chk("wr_busy1", {31'd0, mon_busy}, 32'd1);
        tick();
        chk("wr_busy2", {31'd0, mon_busy}, 32'd0);
        jtag_b(32'hCAFEF00D);
        wait_idle();

        // read with address load, then streaming read at post-incremented address
        jtag_a(8'h10, 1'b1);
        repeat (3) tick();
        pop_mon("rd_load");
        jtag_na();
        repeat (3) tick();
        pop_mon("rd_stream");

        // wrap-around on writes and on streaming reads
        jtag_a(8'hFF, 1'b0);
        jtag_b(32'hA5A50FF0);
        wait_idle();
        jtag_b(32'h00001111);
        wait_idle();
        jtag_a(8'hFF, 1'b1);
        repeat (3) tick();
        pop_mon("rd_ff");
        jtag_na();
        repeat (3) tick();
        pop_mon("rd_wrap");

        // CPU read colliding with a JTAG write to the same word
        jtag_a(8'h20, 1'b0);
        cpu_read(8'h20, 4, 1'b1, 32'h0BADF00D);
        wait_idle();
        cpu_read(8'h10, 2, 1'b0, 32'h0);

        // queue overflow on three back-to-back strobes
        jtag_a(8'h10, 1'b0);
        wait_idle();
        take_na = 1'b1;
        exp_jq.push_back(model_mem[8'h10]);
        exp_jq.push_back(model_mem[8'h11]);
        model_addr = 8'h12;
        repeat (3) tick();
        take_na = 1'b0;
        chk("ovf_err", {31'd0, mon_err}, 32'd1);
        tick();
        pop_mon("ovf_rd0");
        repeat (2) tick();
        pop_mon("ovf_rd1");
        wait_idle();
        chk("ovf_err_hold", {31'd0, mon_err}, 32'd1);
        jtag_a(8'h30, 1'b0);
        chk("ovf_err_clr", {31'd0, mon_err}, 32'd0);

        // CPU writes with and without debug mode
        jtag_a(8'h40, 1'b0);
        jtag_b(32'h0);
        wait_idle();
        debugack = 1'b0;
        cpu_write(8'h40, 32'h12345678, 4'hF);
        cpu_read(8'h40, 2, 1'b0, 32'h0);
        debugack = 1'b1;
        cpu_write(8'h40, 32'hAABBCCDD, 4'b0101);
        cpu_read(8'h40, 2, 1'b0, 32'h0);
        cpu_write(8'h41, 32'h12345678, 4'hF);
        cpu_read(8'h41, 2, 1'b0, 32'h0);

        // reset while a JTAG write is queued aborts it
        jtag_a(8'h50, 1'b0);
        jtag_b(32'h11111111);
        wait_idle();
        jtag_a(8'h50, 1'b0);
        jdo = '0;
        jdo[34:3] = 32'h22222222;
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk_reset("rst2");
        tick();
        model_addr = '0;
        jtag_na();
        repeat (3) tick();
        pop_mon("rst2_rd0");
        jtag_a(8'h50, 1'b1);
        repeat (3) tick();
        pop_mon("rst2_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
